// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Purpose  : Fetch-side PC sequencer and IF/ID pipeline register for a
//            5-stage 32-bit MIPS pipeline. Forms the branch target
//            (pcplus4_d + signimm_sh_d) and the j-type jump target, and drives
//            the instruction-memory address. A taken redirect that arrives
//            while fetch is stalled is captured and applied once the stall
//            releases, so it is never lost.
// Ports    : clk              - clock, all state updates on rising edge
//            reset            - synchronous, active-low reset
//            stall_f          - hold PC
//            stall_d          - hold IF/ID register
//            flush_d          - load NOP into IF/ID (beats stall_d)
//            pcsrc_d          - conditional branch taken (decode)
//            jump_d           - j-type jump in decode (beats pcsrc_d)
//            signimm_sh_d     - sign-extended immediate, already << 2
//            instr_f          - instruction-memory read data for pc_f
//            pc_f             - fetch address
//            instr_d          - IF/ID instruction
//            pcplus4_d        - IF/ID PC+4
//            pcbranch_d       - branch target (combinational)
//            redirect_pending - a stalled redirect is being held
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pcsrc_d,
    input  logic        jump_d,
    input  logic [31:0] signimm_sh_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic [31:0] pcbranch_d,
    output logic        redirect_pending
);

    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_PENDING = 1'b1;
    localparam logic [31:0] c_pc_step = 32'd4;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_saved;
    logic [31:0] w_saved_next;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;

    logic [31:0] w_pcplus4_f;
    logic [31:0] w_pcjump_d;
    logic [31:0] w_target_d;
    logic        w_redirect_d;
    logic        w_load_target;
    logic        w_squash;

    // ------------------------------------------------------------------
    // Target arithmetic (all modulo 2^32)
    // ------------------------------------------------------------------
    assign w_pcplus4_f  = r_pc + c_pc_step;
    assign pcbranch_d   = r_pcplus4_d + signimm_sh_d;
    assign w_pcjump_d   = {r_pcplus4_d[31:28], r_instr_d[25:0], 2'b00};
    assign w_target_d   = jump_d ? w_pcjump_d : pcbranch_d;
    assign w_redirect_d = pcsrc_d | jump_d;

    // ------------------------------------------------------------------
    // State register (FSM state, PC, held redirect target)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_saved <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_saved <= w_saved_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_saved_next = r_saved;
        case (r_state)
            S_IDLE: begin
                if (w_redirect_d) begin
                    if (stall_f) begin
                        // Fetch is frozen: park the target until it thaws.
                        w_saved_next = w_target_d;
                        w_state_next = S_PENDING;
                    end else begin
                        w_pc_next = w_target_d;
                    end
                end else if (!stall_f) begin
                    w_pc_next = w_pcplus4_f;
                end
            end
            S_PENDING: begin
                // New decode redirects are ignored here: the parked one is
                // older and the instructions behind it are wrong-path.
                if (!stall_f) begin
                    w_pc_next    = r_saved;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Alignment bits of the PC always stay those of the reset vector.
        w_pc_next[1:0] = RESET_PC[1:0];
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_load_target    = 1'b0;
        redirect_pending = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_target = w_redirect_d & ~stall_f;
            end
            S_PENDING: begin
                w_load_target    = ~stall_f;
                redirect_pending = 1'b1;
            end
            default: begin
                w_load_target    = 1'b0;
                redirect_pending = 1'b0;
            end
        endcase
        // Whatever sits at pc_f while a redirect is taken or parked is
        // wrong-path and must not enter decode.
        w_squash = w_load_target | redirect_pending;
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr_d   <= NOP_INSTR;
            r_pcplus4_d <= '0;
        end else if (flush_d) begin
            r_instr_d   <= NOP_INSTR;
            r_pcplus4_d <= '0;
        end else if (stall_d) begin
            r_instr_d   <= r_instr_d;
            r_pcplus4_d <= r_pcplus4_d;
        end else if (w_squash) begin
            r_instr_d   <= NOP_INSTR;
            r_pcplus4_d <= '0;
        end else begin
            r_instr_d   <= instr_f;
            r_pcplus4_d <= w_pcplus4_f;
        end
    end

    assign pc_f      = r_pc;
    assign instr_d   = r_instr_d;
    assign pcplus4_d = r_pcplus4_d;

endmodule
`default_nettype wire
